// File: rtl/pong_pkg.sv
// Shared constants for the pong game core and its VGA display stage:
// 640x480@60 timing, playfield geometry and the 2-bit-per-channel palette.
package pong_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int SCREEN_WIDTH  = H_VISIBLE;
    localparam int SCREEN_HEIGHT = V_VISIBLE;
    localparam int BALL_SIZE     = 10;
    localparam int PADDLE_WIDTH  = 10;
    localparam int PADDLE_HEIGHT = 60;
    localparam int BORDER        = 2;

    localparam logic [5:0] COL_BALL   = 6'b111111;
    localparam logic [5:0] COL_PADDLE = 6'b001100;
    localparam logic [5:0] COL_BORDER = 6'b000011;
    localparam logic [5:0] COL_BG     = 6'b000000;

    typedef struct packed {
        logic [9:0] ball_x;
        logic [9:0] ball_y;
        logic [9:0] paddle_y;
    } game_state_t;

    localparam game_state_t GAME_STATE_RST = '{ball_x: 10'd320, ball_y: 10'd240, paddle_y: 10'd210};

endpackage

// File: rtl/vga_timing.sv
// Free-running hpos/vpos raster counters with combinational sync, active-area
// and frame-start decode; the caller registers everything it uses.
module vga_timing
    import pong_pkg::*;
#(
    parameter int H_VIS = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hpos_o,
    output logic [9:0] vpos_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       active_o,
    output logic       frame_start_o
);
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;

    always_comb begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (hpos_q == 10'(H_TOT - 1)) begin
            hpos_d = '0;
            vpos_d = (vpos_q == 10'(V_TOT - 1)) ? '0 : vpos_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    assign hpos_o        = hpos_q;
    assign vpos_o        = vpos_q;
    assign hsync_n_o     = !(hpos_q >= 10'(H_VIS + H_FP) && hpos_q < 10'(H_VIS + H_FP + H_SW));
    assign vsync_n_o     = !(vpos_q >= 10'(V_VIS + V_FP) && vpos_q < 10'(V_VIS + V_FP + V_SW));
    assign active_o      = (hpos_q < 10'(H_VIS)) && (vpos_q < 10'(V_VIS));
    // First blanking line start: safe moment to take a new game-state snapshot.
    assign frame_start_o = (hpos_q == '0) && (vpos_q == 10'(V_VIS));

endmodule

// File: rtl/pong_vga_renderer.sv
// VGA display stage: snapshots game state once per frame, draws ball, paddle and
// border, and registers rgb/syncs/active/frame_tick one cycle behind the counters.
module pong_vga_renderer
    import pong_pkg::*;
#(
    parameter int H_VIS    = H_VISIBLE,
    parameter int H_FP     = H_FRONT,
    parameter int H_SW     = H_SYNC,
    parameter int H_BP     = H_BACK,
    parameter int V_VIS    = V_VISIBLE,
    parameter int V_FP     = V_FRONT,
    parameter int V_SW     = V_SYNC,
    parameter int V_BP     = V_BACK,
    parameter int BALL_SZ  = BALL_SIZE,
    parameter int PAD_W    = PADDLE_WIDTH,
    parameter int PAD_H    = PADDLE_HEIGHT,
    parameter int BORDER_W = BORDER
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_y,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       video_active,
    output logic       frame_tick,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);
    logic [9:0] hpos_c, vpos_c;
    logic       hs_n_c, vs_n_c, act_c, fstart_c;

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .hpos_o        (hpos_c),
        .vpos_o        (vpos_c),
        .hsync_n_o     (hs_n_c),
        .vsync_n_o     (vs_n_c),
        .active_o      (act_c),
        .frame_start_o (fstart_c)
    );

    game_state_t shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (fstart_c) begin
            shadow_d.ball_x   = ball_x;
            shadow_d.ball_y   = ball_y;
            shadow_d.paddle_y = paddle_y;
        end
    end

    // 11-bit compares so an object parked near 1023 cannot wrap onto the left/top edge.
    logic [10:0] h11, v11, bx11, by11, py11;
    logic        ball_hit, pad_hit, border_hit;
    logic [5:0]  pix_c;

    assign h11  = {1'b0, hpos_c};
    assign v11  = {1'b0, vpos_c};
    assign bx11 = {1'b0, shadow_q.ball_x};
    assign by11 = {1'b0, shadow_q.ball_y};
    assign py11 = {1'b0, shadow_q.paddle_y};

    assign ball_hit   = (h11 >= bx11) && (h11 <= bx11 + 11'(BALL_SZ - 1)) &&
                        (v11 >= by11) && (v11 <= by11 + 11'(BALL_SZ - 1));
    assign pad_hit    = (h11 < 11'(PAD_W)) &&
                        (v11 >= py11) && (v11 <= py11 + 11'(PAD_H - 1));
    assign border_hit = (h11 < 11'(BORDER_W)) || (h11 >= 11'(H_VIS - BORDER_W)) ||
                        (v11 < 11'(BORDER_W)) || (v11 >= 11'(V_VIS - BORDER_W));

    always_comb begin
        pix_c = COL_BG;
        if (!act_c)          pix_c = COL_BG;
        else if (ball_hit)   pix_c = COL_BALL;
        else if (pad_hit)    pix_c = COL_PADDLE;
        else if (border_hit) pix_c = COL_BORDER;
    end

    logic       hsync_q, vsync_q, active_q, tick_q;
    logic [5:0] rgb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= GAME_STATE_RST;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            rgb_q    <= COL_BG;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            hsync_q  <= hs_n_c;
            vsync_q  <= vs_n_c;
            rgb_q    <= pix_c;
            active_q <= act_c;
            tick_q   <= fstart_c;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign rgb          = rgb_q;
    assign video_active = active_q;
    assign frame_tick   = tick_q;
    assign hpos         = hpos_c;
    assign vpos         = vpos_c;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench for pong_vga_renderer: a full-size instance for the real 640x480 line
// timing, and a shrunken-raster instance checked cycle by cycle against a model.
module tb_pong_vga_renderer;

    // Shrunken raster so whole frames fit in a short run.
    localparam int S_HV = 64, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VV = 48, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;
    localparam int S_BALL = 4, S_PW = 4, S_PH = 12, S_BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] ball_x = 10'd0, ball_y = 10'd0, paddle_y = 10'd0;

    logic       hsync, vsync, video_active, frame_tick;
    logic [5:0] rgb;
    logic [9:0] hpos, vpos;
    logic       hsync_f, vsync_f, video_active_f, frame_tick_f;
    logic [5:0] rgb_f;
    logic [9:0] hpos_f, vpos_f;

    int checks = 0, errors = 0, cyc = 0;

    // model state
    int mt = 0;
    int sbx = 320, sby = 240, spy = 210;
    int p_h = -1, p_v = -1;
    int e_h = 0, e_v = 0;
    logic e_hs = 1'b1, e_vs = 1'b1, e_act = 1'b0, e_tick = 1'b0;
    logic [5:0] e_rgb = 6'h00;

    always #5 clk = ~clk;

    pong_vga_renderer #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SW(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SW(S_VS), .V_BP(S_VB),
        .BALL_SZ(S_BALL), .PAD_W(S_PW), .PAD_H(S_PH), .BORDER_W(S_BD)
    ) dut (
        .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .video_active(video_active),
        .frame_tick(frame_tick), .hpos(hpos), .vpos(vpos)
    );

    pong_vga_renderer dut_full (
        .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
        .hsync(hsync_f), .vsync(vsync_f), .rgb(rgb_f), .video_active(video_active_f),
        .frame_tick(frame_tick_f), .hpos(hpos_f), .vpos(vpos_f)
    );

    function automatic logic [5:0] ref_rgb(int h, int v, int bx, int by, int py);
        if (h >= S_HV || v >= S_VV) return 6'h00;
        if (h >= bx && h < bx + S_BALL && v >= by && v < by + S_BALL) return 6'h3f;
        if (h < S_PW && v >= py && v < py + S_PH) return 6'h0c;
        if (h < S_BD || h >= S_HV - S_BD || v < S_BD || v >= S_VV - S_BD) return 6'h03;
        return 6'h00;
    endfunction

    // Advance one clock; raster position is just elapsed cycles since reset.
    task automatic tick();
        int h, v;
        h = mt % S_HT;
        v = (mt / S_HT) % S_VT;
        if (rst) begin
            mt = 0; sbx = 320; sby = 240; spy = 210; p_h = -1; p_v = -1;
            e_hs = 1'b1; e_vs = 1'b1; e_rgb = 6'h00; e_act = 1'b0; e_tick = 1'b0;
        end else begin
            e_act  = (h < S_HV) && (v < S_VV);
            e_hs   = !(h >= S_HV + S_HF && h < S_HV + S_HF + S_HS);
            e_vs   = !(v >= S_VV + S_VF && v < S_VV + S_VF + S_VS);
            e_rgb  = ref_rgb(h, v, sbx, sby, spy);
            e_tick = (h == 0) && (v == S_VV);
            if (e_tick) begin
                sbx = int'(ball_x); sby = int'(ball_y); spy = int'(paddle_y);
            end
            p_h = h; p_v = v;
            mt++;
        end
        @(posedge clk); #1;
        e_h = mt % S_HT;
        e_v = (mt / S_HT) % S_VT;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            ball_x = 10'($urandom); ball_y = 10'($urandom); paddle_y = 10'($urandom);
            tick();
            checks++;
            if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 10'd0, 10'd0}) begin
                errors++;
                $display("FAIL reset_small got hs=%b vs=%b rgb=%h act=%b tick=%b h=%0d v=%0d want 1 1 00 0 0 0 0",
                         hsync, vsync, rgb, video_active, frame_tick, hpos, vpos);
            end
            checks++;
            if ({hsync_f, vsync_f, rgb_f, video_active_f, frame_tick_f, hpos_f, vpos_f} !== {1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 10'd0, 10'd0}) begin
                errors++;
                $display("FAIL reset_full got hs=%b vs=%b rgb=%h act=%b tick=%b h=%0d v=%0d want 1 1 00 0 0 0 0",
                         hsync_f, vsync_f, rgb_f, video_active_f, frame_tick_f, hpos_f, vpos_f);
            end
        end
    endtask

    // Real 640x480 line timing on the default-parameter instance.
    task automatic test_full_timing();
        int n, falls, last_fall, run;
        logic prev_hs;
        logic [5:0] want;
        ball_x = 10'd320; ball_y = 10'd240; paddle_y = 10'd210;
        rst = 1'b0;
        n = 0; falls = 0; last_fall = 0; run = 0; prev_hs = hsync_f;
        repeat (2500) begin
            tick();
            n++;
            checks++;
            if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {e_hs, e_vs, e_rgb, e_act, e_tick, 10'(e_h), 10'(e_v)}) begin
                errors++;
                $display("FAIL scan_full_run cyc=%0d got %b%b %h %b%b %0d,%0d want %b%b %h %b%b %0d,%0d", cyc,
                         hsync, vsync, rgb, video_active, frame_tick, hpos, vpos, e_hs, e_vs, e_rgb, e_act, e_tick, e_h, e_v);
            end
            checks++;
            if (hpos_f !== 10'(n % 800) || vpos_f !== 10'(n / 800) || vsync_f !== 1'b1 || frame_tick_f !== 1'b0) begin
                errors++;
                $display("FAIL full_counters n=%0d got h=%0d v=%0d vs=%b tick=%b want h=%0d v=%0d vs=1 tick=0",
                         n, hpos_f, vpos_f, vsync_f, frame_tick_f, n % 800, n / 800);
            end
            if (n <= 800) begin
                want = ((n - 1) < 640) ? 6'h03 : 6'h00;
                checks++;
                if (rgb_f !== want || video_active_f !== ((n - 1) < 640)) begin
                    errors++;
                    $display("FAIL full_row0 col=%0d got rgb=%h act=%b want rgb=%h", n - 1, rgb_f, video_active_f, want);
                end
            end
            if (!hsync_f) run++;
            if (prev_hs && !hsync_f) begin
                checks++;
                if (falls == 0 && n != 657) begin
                    errors++; $display("FAIL full_first_hsync_fall got %0d want 657", n);
                end
                if (falls > 0 && n - last_fall != 800) begin
                    errors++; $display("FAIL full_line_period got %0d want 800", n - last_fall);
                end
                falls++; last_fall = n;
            end
            if (!prev_hs && hsync_f) begin
                checks++;
                if (run != 96) begin
                    errors++; $display("FAIL full_hsync_width got %0d want 96", run);
                end
                run = 0;
            end
            prev_hs = hsync_f;
        end
        checks++;
        if (falls != 3) begin
            errors++; $display("FAIL full_hsync_count got %0d want 3", falls);
        end
    endtask

    task automatic test_hold();
        int lat, budget;
        ball_x = 10'd20; ball_y = 10'd15; paddle_y = 10'd10;
        lat = 0; budget = 0;
        while (lat < 2 && budget < 2 * S_FRAME + 100) begin
            tick(); budget++;
            if (e_tick) lat++;
            checks++;
            if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {e_hs, e_vs, e_rgb, e_act, e_tick, 10'(e_h), 10'(e_v)}) begin
                errors++;
                $display("FAIL scan_hold cyc=%0d got %b%b %h %b%b %0d,%0d want %b%b %h %b%b %0d,%0d", cyc,
                         hsync, vsync, rgb, video_active, frame_tick, hpos, vpos, e_hs, e_vs, e_rgb, e_act, e_tick, e_h, e_v);
            end
            if (lat == 1) begin
                if ((p_h == 20 && p_v == 15) || (p_h == 23 && p_v == 18)) begin
                    checks++;
                    if (rgb !== 6'h3f) begin errors++; $display("FAIL hold_ball (%0d,%0d) got %h want 3f", p_h, p_v, rgb); end
                end
                if ((p_h == 24 && p_v == 15) || (p_h == 2 && p_v == 22)) begin
                    checks++;
                    if (rgb !== 6'h00) begin errors++; $display("FAIL hold_bg (%0d,%0d) got %h want 00", p_h, p_v, rgb); end
                end
                if ((p_h == 2 && p_v == 10) || (p_h == 3 && p_v == 21)) begin
                    checks++;
                    if (rgb !== 6'h0c) begin errors++; $display("FAIL hold_paddle (%0d,%0d) got %h want 0c", p_h, p_v, rgb); end
                end
                if (p_h == 63 && p_v == 30) begin
                    checks++;
                    if (rgb !== 6'h03) begin errors++; $display("FAIL hold_border (63,30) got %h want 03", rgb); end
                end
            end
        end
        checks++;
        if (lat < 2) begin errors++; $display("FAIL hold_timeout latches got %0d want 2", lat); end
    endtask

    task automatic test_mid_change();
        int lat, budget, last_tick_cyc;
        bit changed;
        ball_x = 10'd20; ball_y = 10'd30; paddle_y = 10'd10;
        lat = 0; budget = 0; changed = 0; last_tick_cyc = -1;
        while (lat < 3 && budget < 3 * S_FRAME + 100) begin
            tick(); budget++;
            if (e_tick) lat++;
            checks++;
            if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {e_hs, e_vs, e_rgb, e_act, e_tick, 10'(e_h), 10'(e_v)}) begin
                errors++;
                $display("FAIL scan_mid cyc=%0d got %b%b %h %b%b %0d,%0d want %b%b %h %b%b %0d,%0d", cyc,
                         hsync, vsync, rgb, video_active, frame_tick, hpos, vpos, e_hs, e_vs, e_rgb, e_act, e_tick, e_h, e_v);
            end
            if (frame_tick === 1'b1) begin
                if (last_tick_cyc >= 0) begin
                    checks++;
                    if (cyc - last_tick_cyc != S_FRAME) begin
                        errors++; $display("FAIL tick_period got %0d want %0d", cyc - last_tick_cyc, S_FRAME);
                    end
                end
                last_tick_cyc = cyc;
            end
            if (lat == 1 && !changed && e_h == 0 && e_v == 20) begin
                ball_x = 10'd5; changed = 1;
            end
            if (p_v == 30 && (p_h == 20 || p_h == 5) && lat >= 1 && lat <= 2) begin
                checks++;
                if (rgb !== (((lat == 1) == (p_h == 20)) ? 6'h3f : 6'h00)) begin
                    errors++;
                    $display("FAIL mid_change frame=%0d (%0d,30) got %h want %h", lat, p_h, rgb,
                             ((lat == 1) == (p_h == 20)) ? 6'h3f : 6'h00);
                end
            end
        end
        checks++;
        if (lat < 3) begin errors++; $display("FAIL mid_timeout latches got %0d want 3", lat); end
    endtask

    task automatic test_offscreen();
        int lat, budget;
        ball_x = 10'd1020; ball_y = 10'd1020; paddle_y = 10'd1000;
        lat = 0; budget = 0;
        while (lat < 2 && budget < 2 * S_FRAME + 100) begin
            tick(); budget++;
            if (e_tick) lat++;
            checks++;
            if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {e_hs, e_vs, e_rgb, e_act, e_tick, 10'(e_h), 10'(e_v)}) begin
                errors++;
                $display("FAIL scan_offscreen cyc=%0d got %b%b %h %b%b %0d,%0d want %b%b %h %b%b %0d,%0d", cyc,
                         hsync, vsync, rgb, video_active, frame_tick, hpos, vpos, e_hs, e_vs, e_rgb, e_act, e_tick, e_h, e_v);
            end
            if (lat == 1) begin
                checks++;
                if (rgb !== 6'h00 && rgb !== 6'h03) begin
                    errors++; $display("FAIL offscreen_object (%0d,%0d) got %h want 00 or 03", p_h, p_v, rgb);
                end
            end
        end
        checks++;
        if (lat < 2) begin errors++; $display("FAIL offscreen_timeout latches got %0d want 2", lat); end
    endtask

    task automatic test_overlap();
        int lat, budget;
        ball_x = 10'd0; ball_y = 10'd10; paddle_y = 10'd10;
        lat = 0; budget = 0;
        while (lat < 2 && budget < 2 * S_FRAME + 100) begin
            tick(); budget++;
            if (e_tick) lat++;
            checks++;
            if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {e_hs, e_vs, e_rgb, e_act, e_tick, 10'(e_h), 10'(e_v)}) begin
                errors++;
                $display("FAIL scan_overlap cyc=%0d got %b%b %h %b%b %0d,%0d want %b%b %h %b%b %0d,%0d", cyc,
                         hsync, vsync, rgb, video_active, frame_tick, hpos, vpos, e_hs, e_vs, e_rgb, e_act, e_tick, e_h, e_v);
            end
            if (lat == 1 && p_h == 3 && (p_v == 12 || p_v == 15)) begin
                checks++;
                if (rgb !== ((p_v == 12) ? 6'h3f : 6'h0c)) begin
                    errors++; $display("FAIL overlap_priority (3,%0d) got %h want %h", p_v, rgb, (p_v == 12) ? 6'h3f : 6'h0c);
                end
            end
            if (p_h >= S_HV || p_v >= S_VV) begin
                checks++;
                if (rgb !== 6'h00 || video_active !== 1'b0) begin
                    errors++; $display("FAIL blanking (%0d,%0d) got rgb=%h act=%b want 00 0", p_h, p_v, rgb, video_active);
                end
            end
        end
        checks++;
        if (lat < 2) begin errors++; $display("FAIL overlap_timeout latches got %0d want 2", lat); end
    endtask

    task automatic test_random();
        repeat (2 * S_FRAME) begin
            if ($urandom_range(0, 49) == 0) begin
                ball_x   = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 70));
                ball_y   = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 52));
                paddle_y = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 52));
            end
            tick();
            checks++;
            if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {e_hs, e_vs, e_rgb, e_act, e_tick, 10'(e_h), 10'(e_v)}) begin
                errors++;
                $display("FAIL scan_random cyc=%0d got %b%b %h %b%b %0d,%0d want %b%b %h %b%b %0d,%0d", cyc,
                         hsync, vsync, rgb, video_active, frame_tick, hpos, vpos, e_hs, e_vs, e_rgb, e_act, e_tick, e_h, e_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int budget, n;
        logic prev_hs;
        budget = 0;
        while (e_h != 70 && budget < 2 * S_HT) begin tick(); budget++; end
        checks++;
        if (e_h != 70 || hsync !== 1'b0) begin
            errors++; $display("FAIL reset_mid_setup got h=%0d hs=%b want h=70 hs=0", e_h, hsync);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL reset_mid got hs=%b vs=%b rgb=%h act=%b tick=%b h=%0d v=%0d want 1 1 00 0 0 0 0",
                     hsync, vsync, rgb, video_active, frame_tick, hpos, vpos);
        end
        n = 0; prev_hs = hsync;
        repeat (2 * S_HT) begin
            tick(); n++;
            checks++;
            if ({hsync, vsync, rgb, video_active, frame_tick, hpos, vpos} !== {e_hs, e_vs, e_rgb, e_act, e_tick, 10'(e_h), 10'(e_v)}) begin
                errors++;
                $display("FAIL scan_after_reset cyc=%0d got %b%b %h %b%b %0d,%0d want %b%b %h %b%b %0d,%0d", cyc,
                         hsync, vsync, rgb, video_active, frame_tick, hpos, vpos, e_hs, e_vs, e_rgb, e_act, e_tick, e_h, e_v);
            end
            if (prev_hs && !hsync && n < S_HT) begin
                checks++;
                if (n != S_HV + S_HF + 1) begin
                    errors++; $display("FAIL reset_mid_first_fall got %0d want %0d", n, S_HV + S_HF + 1);
                end
            end
            prev_hs = hsync;
        end
    endtask

    initial begin
        test_reset();
        test_full_timing();
        test_hold();
        test_mid_change();
        test_offscreen();
        test_overlap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
